// File: rtl/mux_n_skid_if.sv
// Handshake/bus bundle for mux_n_skid: upstream N-way data with select,
// downstream registered beat, and a synchronous flush request.
`timescale 1ns/1ps
interface mux_n_skid_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) ();
    logic                    flush_i;
    logic [NUM_IN*WIDTH-1:0] data_i;
    logic [SEL_W-1:0]        select_i;
    logic                    valid_i;
    logic                    ready_o;
    logic [WIDTH-1:0]        data_o;
    logic                    err_o;
    logic                    valid_o;
    logic                    ready_i;

    // Driver / consumer side (the environment around the selector).
    modport master (
        output flush_i, data_i, select_i, valid_i, ready_i,
        input  ready_o, data_o, err_o, valid_o
    );

    // Selector side.
    modport slave (
        input  flush_i, data_i, select_i, valid_i, ready_i,
        output ready_o, data_o, err_o, valid_o
    );
endinterface

// File: rtl/mux_n_skid.sv
// N-way WIDTH-bit selector with a registered output, valid/ready handshake
// and a two-entry (head + skid) buffer. ready_o is decoded from the state
// register only, so there is no combinational path from ready_i to ready_o.
`timescale 1ns/1ps
module mux_n_skid #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mux_n_skid_if.slave  bus
);

    generate
        if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
            $error("mux_n_skid: NUM_IN must be in 2..16");
        end
        if ((2 ** SEL_W) < NUM_IN) begin : g_bad_sel_w
            $error("mux_n_skid: SEL_W too narrow to address NUM_IN inputs");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   head_data_q, skid_data_q;
    logic               head_err_q, skid_err_q;

    logic [WIDTH-1:0]   slice [NUM_IN];
    logic [WIDTH-1:0]   sel_data;
    logic               sel_hit;
    logic               accept, pop;
    logic               load_head, load_skid, move_skid;

    // Unpack the flat input bus; only in-range slices exist, so an
    // out-of-range select can never read past data_i.
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_slice
        assign slice[gi] = bus.data_i[gi*WIDTH +: WIDTH];
    end

    // Select the addressed input; a miss yields zero data and flags an error.
    always_comb begin
        sel_data = '0;
        sel_hit  = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.select_i == SEL_W'(k)) begin
                sel_data = slice[k];
                sel_hit  = 1'b1;
            end
        end
    end

    assign bus.valid_o = (state_q != ST_EMPTY);
    assign bus.ready_o = (state_q != ST_TWO);
    assign bus.data_o  = head_data_q;
    assign bus.err_o   = head_err_q;

    assign accept = bus.valid_i && bus.ready_o;
    assign pop    = bus.valid_o && bus.ready_i;

    // Next-state and buffer-steering decode; flush overrides to EMPTY.
    always_comb begin
        state_d   = state_q;
        load_head = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d   = ST_ONE;
                    load_head = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && !pop) begin
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end else if (accept && pop) begin
                    load_head = 1'b1;
                end else if (pop) begin
                    state_d   = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_d   = ST_ONE;
                    move_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Buffered contents become invalid; data registers may keep stale values.
        if (bus.flush_i) begin
            state_d = ST_EMPTY;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Head and skid beat registers; head takes a fresh beat or the skid entry.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            head_data_q <= '0;
            head_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            if (load_head) begin
                head_data_q <= sel_data;
                head_err_q  <= ~sel_hit;
            end else if (move_skid) begin
                head_data_q <= skid_data_q;
                head_err_q  <= skid_err_q;
            end
            if (load_skid) begin
                skid_data_q <= sel_data;
                skid_err_q  <= ~sel_hit;
            end
        end
    end

endmodule

// File: tb/tb_mux_n_skid.sv
// Directed bench for mux_n_skid: a 4-input instance for the main behaviour
// and a 3-input instance for out-of-range select handling.
`timescale 1ns/1ps
module tb_mux_n_skid;

    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;

    mux_n_skid_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) bus4 ();
    mux_n_skid_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) bus3 ();

    mux_n_skid #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dut4 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus4.slave)
    );

    mux_n_skid #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut3 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus4.flush_i = 0; bus4.data_i = '0; bus4.select_i = '0;
        bus4.valid_i = 0; bus4.ready_i = 0;
        bus3.flush_i = 0; bus3.data_i = '0; bus3.select_i = '0;
        bus3.valid_i = 0; bus3.ready_i = 0;
    endtask

    task automatic test_reset();
        idle_all();
        rst_n = 1'b0;
        #12;
        vec_cnt++;
        if (bus4.valid_o !== 1'b0 || bus4.ready_o !== 1'b1 ||
            bus4.data_o !== 32'h0 || bus4.err_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset: valid=%b ready=%b data=%h err=%b, want 0 1 00000000 0",
                     bus4.valid_o, bus4.ready_o, bus4.data_o, bus4.err_o);
        end
        rst_n = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        bus4.valid_i = 1; bus4.select_i = 2; bus4.ready_i = 1;
        bus4.data_i[2*32 +: 32] = 32'hDEAD_BEEF;
        step();
        bus4.valid_i = 0;
        vec_cnt++;
        if (bus4.valid_o !== 1'b1 || bus4.data_o !== 32'hDEAD_BEEF || bus4.err_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_capture: valid=%b data=%h err=%b, want 1 deadbeef 0",
                     bus4.valid_o, bus4.data_o, bus4.err_o);
        end
        step();
        vec_cnt++;
        if (bus4.valid_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_drain: valid=%b, want 0", bus4.valid_o);
        end
        $display("test_basic done: beat deadbeef");
    endtask

    task automatic test_backpressure();
        bus4.ready_i = 0; bus4.select_i = 0;
        bus4.valid_i = 1; bus4.data_i[0 +: 32] = 32'd1;   // A
        step();
        vec_cnt++;
        if (bus4.ready_o !== 1'b1 || bus4.valid_o !== 1'b1 || bus4.data_o !== 32'd1) begin
            err_cnt++;
            $display("FAIL bp_after_a: ready=%b valid=%b data=%h, want 1 1 1",
                     bus4.ready_o, bus4.valid_o, bus4.data_o);
        end
        bus4.data_i[0 +: 32] = 32'd2;                     // B
        step();
        vec_cnt++;
        if (bus4.ready_o !== 1'b0 || bus4.data_o !== 32'd1) begin
            err_cnt++;
            $display("FAIL bp_after_b: ready=%b data=%h, want 0 1", bus4.ready_o, bus4.data_o);
        end
        bus4.data_i[0 +: 32] = 32'd3;                     // C, held off
        step();
        vec_cnt++;
        if (bus4.ready_o !== 1'b0 || bus4.valid_o !== 1'b1 || bus4.data_o !== 32'd1) begin
            err_cnt++;
            $display("FAIL bp_stall_hold: ready=%b valid=%b data=%h, want 0 1 1",
                     bus4.ready_o, bus4.valid_o, bus4.data_o);
        end
        bus4.ready_i = 1;
        step();                                           // A popped, B to head
        vec_cnt++;
        if (bus4.data_o !== 32'd2 || bus4.valid_o !== 1'b1 || bus4.ready_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL bp_pop_a: data=%h valid=%b ready=%b, want 2 1 1",
                     bus4.data_o, bus4.valid_o, bus4.ready_o);
        end
        step();                                           // C accepted, B popped
        bus4.valid_i = 0;
        vec_cnt++;
        if (bus4.data_o !== 32'd3 || bus4.valid_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL bp_pop_b: data=%h valid=%b, want 3 1", bus4.data_o, bus4.valid_o);
        end
        step();
        vec_cnt++;
        if (bus4.valid_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_drain: valid=%b, want 0 (duplicate beat)", bus4.valid_o);
        end
        $display("test_backpressure done: beats 1 2 3");
    endtask

    task automatic test_streaming();
        logic [31:0] words [4];
        logic [1:0]  sel;
        logic [31:0] exp;
        bus4.ready_i = 1;
        for (int i = 0; i < 100; i++) begin
            for (int k = 0; k < 4; k++) begin
                words[k] = $urandom;
                bus4.data_i[k*32 +: 32] = words[k];
            end
            sel = 2'($urandom_range(0, 3));
            exp = words[sel];
            bus4.select_i = sel;
            bus4.valid_i  = 1;
            step();
            vec_cnt++;
            if (bus4.valid_o !== 1'b1 || bus4.data_o !== exp ||
                bus4.err_o !== 1'b0 || bus4.ready_o !== 1'b1) begin
                err_cnt++;
                $display("FAIL stream[%0d]: valid=%b data=%h err=%b ready=%b, want 1 %h 0 1",
                         i, bus4.valid_o, bus4.data_o, bus4.err_o, bus4.ready_o, exp);
            end
        end
        bus4.valid_i = 0;
        step();
        vec_cnt++;
        if (bus4.valid_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL stream_drain: valid=%b, want 0", bus4.valid_o);
        end
        $display("test_streaming done: 100 beats");
    endtask

    task automatic test_out_of_range();
        bus3.ready_i = 1; bus3.valid_i = 1;
        bus3.data_i = '1; bus3.select_i = 3;
        step();
        vec_cnt++;
        if (bus3.valid_o !== 1'b1 || bus3.data_o !== 32'h0 || bus3.err_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL oor_sel3: valid=%b data=%h err=%b, want 1 00000000 1",
                     bus3.valid_o, bus3.data_o, bus3.err_o);
        end
        bus3.select_i = 0;
        step();
        vec_cnt++;
        if (bus3.data_o !== 32'hFFFF_FFFF || bus3.err_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL oor_sel0: data=%h err=%b, want ffffffff 0", bus3.data_o, bus3.err_o);
        end
        bus3.select_i = 2; bus3.data_i[2*32 +: 32] = 32'h1234_5678;
        step();
        bus3.valid_i = 0;
        vec_cnt++;
        if (bus3.data_o !== 32'h1234_5678 || bus3.err_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL oor_sel_last: data=%h err=%b, want 12345678 0", bus3.data_o, bus3.err_o);
        end
        step();
        bus3.ready_i = 0;
        $display("test_out_of_range done");
    endtask

    task automatic test_flush();
        bus4.ready_i = 0; bus4.select_i = 1; bus4.valid_i = 1;
        bus4.data_i[1*32 +: 32] = 32'd5;
        step();
        bus4.data_i[1*32 +: 32] = 32'd6;
        step();
        bus4.valid_i = 0;
        vec_cnt++;
        if (bus4.ready_o !== 1'b0 || bus4.data_o !== 32'd5) begin
            err_cnt++;
            $display("FAIL flush_fill: ready=%b data=%h, want 0 5", bus4.ready_o, bus4.data_o);
        end
        bus4.flush_i = 1; bus4.ready_i = 1;
        #1;
        vec_cnt++;                                        // beat 5 offered to the pop
        if (bus4.valid_o !== 1'b1 || bus4.data_o !== 32'd5) begin
            err_cnt++;
            $display("FAIL flush_pop: valid=%b data=%h, want 1 5", bus4.valid_o, bus4.data_o);
        end
        step();
        bus4.flush_i = 0;
        vec_cnt++;
        if (bus4.valid_o !== 1'b0 || bus4.ready_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL flush_empty: valid=%b ready=%b, want 0 1", bus4.valid_o, bus4.ready_o);
        end
        step();
        vec_cnt++;
        if (bus4.valid_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_no_6: valid=%b data=%h, want valid 0", bus4.valid_o, bus4.data_o);
        end
        // A beat accepted in the flush cycle is dropped.
        bus4.valid_i = 1; bus4.flush_i = 1;
        step();
        bus4.valid_i = 0; bus4.flush_i = 0;
        vec_cnt++;
        if (bus4.valid_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_drop_accept: valid=%b, want 0", bus4.valid_o);
        end
        $display("test_flush done: beat 5 delivered, 6 dropped");
    endtask

    task automatic test_async_reset();
        bus4.ready_i = 0; bus4.select_i = 0; bus4.valid_i = 1;
        bus4.data_i[0 +: 32] = 32'h8;
        step();
        bus4.data_i[0 +: 32] = 32'h9;
        step();
        bus4.valid_i = 0;
        vec_cnt++;
        if (bus4.ready_o !== 1'b0 || bus4.valid_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL arst_fill: ready=%b valid=%b, want 0 1", bus4.ready_o, bus4.valid_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (bus4.valid_o !== 1'b0 || bus4.data_o !== 32'h0 || bus4.ready_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL arst_immediate: valid=%b data=%h ready=%b, want 0 00000000 1",
                     bus4.valid_o, bus4.data_o, bus4.ready_o);
        end
        #3;
        rst_n = 1'b1;
        step();
        bus4.ready_i = 1; bus4.valid_i = 1; bus4.select_i = 1;
        bus4.data_i[1*32 +: 32] = 32'h7;
        step();
        bus4.valid_i = 0;
        vec_cnt++;
        if (bus4.valid_o !== 1'b1 || bus4.data_o !== 32'h7) begin
            err_cnt++;
            $display("FAIL arst_beat7: valid=%b data=%h, want 1 7", bus4.valid_o, bus4.data_o);
        end
        step();
        vec_cnt++;
        if (bus4.valid_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL arst_drain: valid=%b, want 0", bus4.valid_o);
        end
        $display("test_async_reset done: beat 7 delivered");
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_streaming();
        test_out_of_range();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mux_n_skid.md
Name: mux_n_skid

Overview:
- Parametrised N-way, WIDTH-bit selector with a registered output, a valid/ready handshake and a two-entry skid buffer.
- Successor to the fixed 4-input combinational selector used in the datapath.
- Sits between pipeline stages (forwarding and writeback select) where the consumer may stall. Gives full throughput with no combinational path from ready_i to ready_o.
- Adds flush and out-of-range select detection.

Parameters:
- WIDTH, 32, bit width of each input and of the output.
- NUM_IN, 4, number of selectable inputs (2..16).
- SEL_W, 2, width of select_i. Must satisfy 2**SEL_W >= NUM_IN; elaboration fails otherwise.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush; drops all buffered beats.
- data_i  in  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- select_i  in  SEL_W  index of the input to capture.
- valid_i  in  1  upstream beat valid.
- ready_o  out  1  block can accept a beat; registered.
- data_o  out  WIDTH  head beat data; registered.
- err_o  out  1  head beat was captured with select_i >= NUM_IN.
- valid_o  out  1  head beat valid.
- ready_i  in  1  downstream accepts the head beat.

Behaviour:
- Transfers:
  - Upstream accept = valid_i && ready_o.
  - Downstream pop = valid_o && ready_i.
- Capture, on accept:
  - Beat data = data_i slice selected by select_i.
  - If select_i >= NUM_IN, beat data = 0 and the beat's err bit = 1; otherwise err bit = 0.
  - select_i and data_i are don't-care when valid_i = 0.
- Storage:
  - Head register holds data_o/err_o. Skid register holds one further beat.
  - Order is strictly FIFO.
- States and ready/valid:
  - EMPTY: valid_o=0, ready_o=1.
  - ONE: valid_o=1, ready_o=1.
  - TWO: valid_o=1, ready_o=0.
- Transitions (pop is only possible in ONE or TWO):
  - EMPTY + accept -> ONE; the beat goes to head.
  - ONE + accept + no pop -> TWO; the beat goes to skid.
  - ONE + accept + pop -> ONE; the new beat goes to head.
  - ONE + pop + no accept -> EMPTY.
  - TWO + pop -> ONE; skid moves to head. No accept is possible in TWO.
  - All other cases hold state.
- Latency: 1 cycle from accept to valid_o when EMPTY. Throughput is 1 beat/cycle when ready_i stays high.
- ready_o depends only on state; it never combinationally depends on ready_i or valid_i.
- data_o/err_o hold their value while valid_o=1 and ready_i=0 (stable-until-taken).
- data_o/err_o in EMPTY: hold the last popped beat. Not checked by the bench.
- Flush (flush_i=1 at a clock edge):
  - Next state is EMPTY; both entries are invalidated.
  - A beat accepted in the same cycle is dropped.
  - A pop in the same cycle still counts as delivered to downstream.
  - Data registers need not be cleared.
- Reset (rst_i=0, asynchronous):
  - State = EMPTY, valid_o=0, ready_o=1, data_o=0, err_o=0, skid register=0.
  - Takes effect immediately, including mid-transfer; all buffered beats are lost.
  - Release is synchronous to clk_i on the rising side of rst_i.
- Width rules: no arithmetic. Slice index = select_i zero-extended. Out-of-range indices never read beyond data_i.

Test Plan:
- Reset and basic capture: rst_i low then released. Drive valid_i=1, select_i=2, input2=32'hDEAD_BEEF, ready_i=1 for one cycle -> next cycle valid_o=1, data_o=DEAD_BEEF, err_o=0; the cycle after, valid_o=0.
- Back-pressure: ready_i=0; send beats A=1, B=2, C=3 on consecutive cycles with valid_i=1.
  - After A: ready_o=1, state ONE. After B: ready_o=0, state TWO.
  - C is held upstream until ready_o rises.
  - Raise ready_i -> data_o shows 1, 2, 3 in order; no loss or duplication.
- Streaming: ready_i=1, 100 back-to-back beats with random select_i in 0..3 -> output matches a reference model beat-for-beat, 1-cycle latency, ready_o constantly 1.
- Out-of-range select: NUM_IN=3, SEL_W=2, select_i=3, all inputs=32'hFFFF_FFFF -> data_o=0, err_o=1. The following beat with select_i=0 -> err_o=0.
- Flush in TWO with a simultaneous pop: state TWO holding beats 5, 6; flush_i=1 and ready_i=1 in the same cycle -> beat 5 is counted delivered; next cycle valid_o=0, ready_o=1; beat 6 never appears.
- Async reset mid-stream: state TWO; pull rst_i low between clock edges -> valid_o=0 and data_o=0 immediately, ready_o=1. After release, a new beat 7 is delivered with 1-cycle latency.
